// File: rtl/kl_arb_pkg.sv
// Shared types and helpers for the CAL_KL memory request arbiter.
package kl_arb_pkg;

  localparam int unsigned ADDR_W = 42;
  localparam int unsigned RN_W   = 9;
  localparam int unsigned TAG_W  = RN_W + 1;

  localparam logic KL_SEL_K = 1'b0;
  localparam logic KL_SEL_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_K = 2'd1,
    ISSUE_L = 2'd2
  } kl_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_l;
    logic [RN_W-1:0]   read_num;
  } kl_pair_t;

  // Memory tag layout: read number in the upper bits, k/l select in the LSB.
  function automatic logic [TAG_W-1:0] kl_pack_tag(input logic [RN_W-1:0] rn, input logic sel);
    return {rn, sel};
  endfunction

endpackage

// File: rtl/kl_pair_fifo.sv
// Synchronous pair FIFO; exposes head and the entry behind it for back-to-back issue.
module kl_pair_fifo
  import kl_arb_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  kl_pair_t         din,
  output kl_pair_t         head,
  output kl_pair_t         second,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  kl_pair_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally; count disambiguates full from empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kl_mem_req_arbiter.sv
// Serializes k/l address pairs onto the shared memory read port with credit tracking.
// Optional same-line merge enabled by defining KL_SAME_LINE_MERGE_EN.
module kl_mem_req_arbiter
  import kl_arb_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH      = 8,
  parameter  int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr_k,
  input  logic [ADDR_W-1:0] req_addr_l,
  input  logic [RN_W-1:0]   req_read_num,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic              mem_req_both,
  input  logic              mem_rsp_valid,
  output logic [OUT_W-1:0]  outstanding,
  output logic              idle
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef KL_SAME_LINE_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  kl_state_e         state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              both_q, both_d;
  logic [OUT_W-1:0]  outst_q, outst_d;

  kl_pair_t          push_pair;
  kl_pair_t          head;
  kl_pair_t          second;
  kl_pair_t          next_pair;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fire;
  logic              rsp_eff;
  logic              credit_ok;
  logic              have_next;

  assign push_pair = '{addr_k: req_addr_k, addr_l: req_addr_l, read_num: req_read_num};
  assign push      = req_valid & ~full;
  assign fire      = valid_q & mem_req_ready;
  assign rsp_eff   = mem_rsp_valid & (outst_q != '0);

  kl_pair_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .din    (push_pair),
    .head   (head),
    .second (second),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Credit bookkeeping; a response with nothing in flight is dropped.
  always_comb begin
    outst_d = outst_q;
    if (fire && !rsp_eff)      outst_d = outst_q + OUT_W'(1);
    else if (!fire && rsp_eff) outst_d = outst_q - OUT_W'(1);
  end

  assign credit_ok = (outst_d < OUT_W'(MAX_OUTSTANDING));

  // Pair following the popped head; may be the one being pushed this cycle.
  assign have_next = (count > CNT_W'(1)) | ((count == CNT_W'(1)) & push);
  assign next_pair = (count > CNT_W'(1)) ? second : push_pair;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    both_d  = both_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        both_d  = 1'b0;
        if (!empty) state_d = ISSUE_K;
      end
      ISSUE_K: begin
        if (!valid_q) begin
          if (credit_ok) begin
            valid_d = 1'b1;
            addr_d  = head.addr_k;
            tag_d   = kl_pack_tag(head.read_num, KL_SEL_K);
            both_d  = MERGE_EN && (head.addr_k == head.addr_l);
          end
        end else if (fire) begin
          if (both_q) begin
            pop = 1'b1;
          end else begin
            state_d = ISSUE_L;
            valid_d = credit_ok;
            addr_d  = head.addr_l;
            tag_d   = kl_pack_tag(head.read_num, KL_SEL_L);
            both_d  = 1'b0;
          end
        end
      end
      ISSUE_L: begin
        if (!valid_q) begin
          if (credit_ok) begin
            valid_d = 1'b1;
            addr_d  = head.addr_l;
            tag_d   = kl_pack_tag(head.read_num, KL_SEL_L);
            both_d  = 1'b0;
          end
        end else if (fire) begin
          pop = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Head retired: preload the next pair's k request to keep one request per cycle.
    if (pop) begin
      if (have_next) begin
        state_d = ISSUE_K;
        valid_d = credit_ok;
        addr_d  = next_pair.addr_k;
        tag_d   = kl_pack_tag(next_pair.read_num, KL_SEL_K);
        both_d  = MERGE_EN && (next_pair.addr_k == next_pair.addr_l);
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        both_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      tag_q   <= '0;
      both_q  <= 1'b0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      both_q  <= both_d;
      outst_q <= outst_d;
    end
  end

  assign stall         = full;
  assign mem_req_valid = valid_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_tag   = tag_q;
  assign outstanding   = outst_q;
  assign idle          = empty & (state_q == IDLE) & (outst_q == '0);

`ifdef KL_SAME_LINE_MERGE_EN
  assign mem_req_both = both_q;
`else
  assign mem_req_both = 1'b0;
`endif

endmodule

// File: tb/tb_kl_mem_req_arbiter.sv
// Directed bench for kl_mem_req_arbiter with a request scoreboard.
module tb_kl_mem_req_arbiter;

  localparam int unsigned AW = 42;
  localparam int unsigned RW = 9;
  localparam int unsigned TW = RW + 1;
  localparam int unsigned OW = 5;

`ifdef KL_SAME_LINE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr_k = '0;
  logic [AW-1:0] req_addr_l = '0;
  logic [RW-1:0] req_read_num = '0;
  logic          stall;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_both;
  logic          mem_rsp_valid = 1'b0;
  logic [OW-1:0] outstanding;
  logic          idle;

  kl_mem_req_arbiter #(
    .FIFO_DEPTH      (8),
    .MAX_OUTSTANDING (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr_k    (req_addr_k),
    .req_addr_l    (req_addr_l),
    .req_read_num  (req_read_num),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_tag   (mem_req_tag),
    .mem_req_both  (mem_req_both),
    .mem_rsp_valid (mem_rsp_valid),
    .outstanding   (outstanding),
    .idle          (idle)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic          both;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_checks = 0;
  int   fires = 0;
  int   cyc = 0;
  int   last_fire_cyc = 0;
  int   prev_fire_cyc = 0;
  int   base = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [AW-1:0] a, input logic [RW-1:0] rn, input logic sel,
                            input logic both);
    exp_t e;
    e.addr = a;
    e.tag  = {rn, sel};
    e.both = both;
    exp_q.push_back(e);
  endtask

  task automatic push_pair(input logic [AW-1:0] k, input logic [AW-1:0] l, input logic [RW-1:0] rn);
    int g = 0;
    req_valid    = 1'b1;
    req_addr_k   = k;
    req_addr_l   = l;
    req_read_num = rn;
    while (stall && g < 500) begin
      tick(1);
      g++;
    end
    if (g >= 500) check("push_timeout", 64'(stall), 64'd0);
    if (MERGE && k == l) begin
      expect_req(k, rn, 1'b0, 1'b1);
    end else begin
      expect_req(k, rn, 1'b0, 1'b0);
      expect_req(l, rn, 1'b1, 1'b0);
    end
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_fires(input int n, input string tag);
    int g = 0;
    while (fires < n && g < 300) begin
      tick(1);
      g++;
    end
    check(tag, 64'(fires), 64'(n));
  endtask

  // Scoreboard: every accepted memory request must match the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst && mem_req_valid && mem_req_ready) begin
      prev_fire_cyc = last_fire_cyc;
      last_fire_cyc = cyc;
      fires++;
      check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("req_addr", 64'(mem_req_addr), 64'(e.addr));
        check("req_tag", 64'(mem_req_tag), 64'(e.tag));
        check("req_both", 64'(mem_req_both), 64'(e.both));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    // Reset values
    tick(2);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_valid", 64'(mem_req_valid), 64'd0);
    check("rst_addr", 64'(mem_req_addr), 64'd0);
    check("rst_tag", 64'(mem_req_tag), 64'd0);
    check("rst_both", 64'(mem_req_both), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_outst", 64'(outstanding), 64'd0);
    rst = 1'b1;
    tick(2);

    // Single pair with ready high
    mem_req_ready = 1'b1;
    base = fires;
    push_pair(42'h100, 42'h200, 9'd5);
    wait_fires(base + 2, "single_fires");
    check("single_back_to_back", 64'(last_fire_cyc - prev_fire_cyc), 64'd1);
    check("single_outst", 64'(outstanding), 64'd2);
    mem_rsp_valid = 1'b1;
    tick(2);
    mem_rsp_valid = 1'b0;
    check("single_outst_drained", 64'(outstanding), 64'd0);
    check("single_idle", 64'(idle), 64'd1);

    // Response with nothing in flight saturates at zero
    mem_rsp_valid = 1'b1;
    tick(1);
    mem_rsp_valid = 1'b0;
    check("rsp_saturate", 64'(outstanding), 64'd0);

    // Back-pressure: fill the FIFO with ready low
    mem_req_ready = 1'b0;
    base = fires;
    for (int i = 0; i < 8; i++) push_pair(42'h1000 + 42'(i), 42'h2000 + 42'(i), 9'(i));
    check("bp_stall_full", 64'(stall), 64'd1);
    req_valid    = 1'b1;
    req_addr_k   = 42'hDEAD;
    req_addr_l   = 42'hBEEF;
    req_read_num = 9'h1FF;
    tick(3);
    check("bp_stall_held", 64'(stall), 64'd1);
    check("bp_no_fire", 64'(fires), 64'(base));
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    wait_fires(base + 2, "bp_first_pair");
    check("bp_stall_released", 64'(stall), 64'd0);
    wait_fires(base + 16, "bp_all_fires");
    tick(3);
    check("bp_fire_total", 64'(fires), 64'(base + 16));
    check("bp_outst_max", 64'(outstanding), 64'd16);
    check("bp_valid_low", 64'(mem_req_valid), 64'd0);
    check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    mem_rsp_valid = 1'b1;
    tick(16);
    mem_rsp_valid = 1'b0;
    check("bp_outst_drained", 64'(outstanding), 64'd0);

    // Credit limit: no responses, more pairs than credits
    base = fires;
    for (int i = 0; i < 10; i++) push_pair(42'h4000 + 42'(i), 42'h5000 + 42'(i), 9'(9'h40 + 9'(i)));
    tick(20);
    check("credit_fires", 64'(fires), 64'(base + 16));
    check("credit_outst", 64'(outstanding), 64'd16);
    check("credit_valid_low", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    tick(1);
    mem_rsp_valid = 1'b0;
    tick(8);
    check("credit_one_more", 64'(fires), 64'(base + 17));
    check("credit_outst_again", 64'(outstanding), 64'd16);
    check("credit_valid_low2", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    tick(30);
    mem_rsp_valid = 1'b0;
    check("credit_all_fires", 64'(fires), 64'(base + 20));
    check("credit_outst_drained", 64'(outstanding), 64'd0);
    check("credit_idle", 64'(idle), 64'd1);
    check("credit_sb_empty", 64'(exp_q.size()), 64'd0);

    // Hold/stable while the l request is stalled
    mem_req_ready = 1'b0;
    base = fires;
    push_pair(42'hAAA, 42'hBBB, 9'd3);
    g = 0;
    while (!mem_req_valid && g < 50) begin
      tick(1);
      g++;
    end
    check("hold_k_valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    check("hold_outst_k", 64'(outstanding), 64'd1);
    for (int i = 0; i < 2; i++) begin
      check("hold_l_valid", 64'(mem_req_valid), 64'd1);
      check("hold_l_addr", 64'(mem_req_addr), 64'h0BBB);
      check("hold_l_tag", 64'(mem_req_tag), 64'({9'd3, 1'b1}));
      tick(1);
    end
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    tick(1);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check("hold_fire_and_rsp", 64'(outstanding), 64'd1);
    check("hold_fires", 64'(fires), 64'(base + 2));
    mem_rsp_valid = 1'b1;
    tick(1);
    mem_rsp_valid = 1'b0;
    check("hold_outst_drained", 64'(outstanding), 64'd0);

    // Same-line pair: merged or split depending on build
    mem_req_ready = 1'b1;
    base = fires;
    push_pair(42'h3C0, 42'h3C0, 9'd7);
    wait_fires(base + (MERGE ? 1 : 2), "merge_fires");
    tick(3);
    check("merge_fire_total", 64'(fires), 64'(base + (MERGE ? 1 : 2)));
    check("merge_outst", 64'(outstanding), MERGE ? 64'd1 : 64'd2);
    check("merge_idle_pending", 64'(idle), 64'd0);
    mem_rsp_valid = 1'b1;
    tick(3);
    mem_rsp_valid = 1'b0;
    check("merge_outst_drained", 64'(outstanding), 64'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) push_pair(42'h7000 + 42'(i), 42'h7100 + 42'(i), 9'(9'h80 + 9'(i)));
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(mem_req_valid), 64'd0);
    check("mid_rst_addr", 64'(mem_req_addr), 64'd0);
    check("mid_rst_tag", 64'(mem_req_tag), 64'd0);
    check("mid_rst_both", 64'(mem_req_both), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_idle", 64'(idle), 64'd1);
    check("mid_rst_outst", 64'(outstanding), 64'd0);
    tick(3);
    rst = 1'b1;
    exp_q.delete();
    base = fires;
    tick(6);
    check("post_rst_no_req", 64'(fires), 64'(base));
    check("post_rst_idle", 64'(idle), 64'd1);
    check("post_rst_outst", 64'(outstanding), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kl_mem_req_arbiter.md
Name: kl_mem_req_arbiter

Overview:
- Sits between the CAL_KL backward-extension stage and the single shared memory read port.
- Accepts one k/l address pair per cycle from the stage, buffers pairs in a small FIFO, and issues them to memory as two serialized requests, k first then l, tagged with read number and k/l select.
- Tracks outstanding memory reads and drives `stall` back to the stage when the FIFO or credits run out.

Parameters:
- FIFO_DEPTH, 8, pair-FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 16, max issued-but-unanswered memory reads.
- ADDR_W, 42, memory address width; matches stage addr_k/addr_l.
- RN_W, 9, read-number width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  pair valid from stage; qualified by !stall.
- req_addr_k  in  ADDR_W  k line address.
- req_addr_l  in  ADDR_W  l line address.
- req_read_num  in  RN_W  read number of the pair.
- stall  out  1  back-pressure to the stage.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_tag  out  RN_W+1  {read_num, sel}; sel=0 for k, 1 for l.
- mem_req_both  out  1  request answers both k and l (merge feature only; else 0).
- mem_rsp_valid  in  1  one memory response returned this cycle.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current credit usage.
- idle  out  1  FIFO empty, FSM in IDLE, outstanding==0.

Behaviour:
- Reset (rst=0, async): FIFO empty, FSM IDLE, outstanding=0.
  - Outputs: stall=0, mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, mem_req_both=0, idle=1.
  - Reset mid-burst drops all buffered pairs and in-flight accounting.
- Accept: push = req_valid & !stall. Pair {addr_k, addr_l, read_num} is written at the clock edge.
- stall = (fifo_count == FIFO_DEPTH).
  - Combinational from registered state only; no path from req_valid.
  - A push and a pop in the same cycle while full is not allowed, because stall is already high.
- FSM states: IDLE, ISSUE_K, ISSUE_L.
  - IDLE: if FIFO non-empty, go to ISSUE_K next cycle. Head is not popped yet.
  - ISSUE_K: mem_req_valid=1 when outstanding<MAX_OUTSTANDING; addr=head.addr_k, tag={rn,0}.
    - On fire (valid & ready): go to ISSUE_L.
  - ISSUE_L: same credit gating; addr=head.addr_l, tag={rn,1}.
    - On fire: pop head.
    - If FIFO still holds another entry after the pop, go to ISSUE_K; otherwise go to IDLE.
- Request outputs are registered and held stable while valid & !ready.
  - mem_req_valid may only drop after a fire.
  - mem_req_valid is deasserted in IDLE.
  - Credit gating never withdraws a valid that is already asserted. The check is made before raising valid.
- Outstanding counter:
  - +1 on fire, -1 on mem_rsp_valid; fire and response in the same cycle leave it unchanged.
  - mem_rsp_valid when outstanding==0 is ignored; the counter saturates at 0.
  - Counter never exceeds MAX_OUTSTANDING.
- Throughput: with ready held high, sustained one memory request per cycle. IDLE is visited only when the FIFO is empty.
- Ordering: pairs are issued in acceptance order; k always precedes l of the same pair.
- FIFO pointers wrap modulo FIFO_DEPTH; count is kept separately so full and empty are unambiguous.

Optional Feature:
- Macro: KL_SAME_LINE_MERGE_EN.
- Defined:
  - In ISSUE_K, if head.addr_k == head.addr_l, issue a single request with tag={rn,0} and mem_req_both=1.
  - On fire, pop the head and skip ISSUE_L.
  - Consumes one credit.
- Undefined: mem_req_both is tied 0, and every pair produces two requests.

Decomposition:
- Package kl_arb_pkg holds:
  - FSM state enum (IDLE, ISSUE_K, ISSUE_L).
  - KL_SEL_K=0 and KL_SEL_L=1.
  - Pair-entry struct typedef {addr_k, addr_l, read_num}.
  - Tag-packing helper function.
- Sub-module kl_pair_fifo: synchronous FIFO with push, pop, head, count, full and empty.

Test Plan:
- Reset then idle: rst low for 3 cycles mid-traffic -> outputs at reset values, idle=1, outstanding=0.
- Single pair, ready=1: push k=0x100, l=0x200, rn=5 -> requests are 0x100 tag {5,0}, then 0x200 tag {5,1} on consecutive cycles; outstanding=2; two responses -> 0, idle=1.
- Back-pressure: ready=0, push 8 pairs -> stall=1 after the 8th; a 9th req_valid is not accepted; release ready -> 16 requests in order, stall drops after the first pop.
- Credit limit: no responses, continuous pairs -> exactly 16 fires, then valid is held low; one mem_rsp_valid -> exactly one further fire.
- Hold/stable: ready toggles 0,0,1 while in ISSUE_L -> addr and tag are unchanged until the fire; simultaneous fire and response leave outstanding unchanged.
- Merge (KL_SAME_LINE_MERGE_EN): pair k=l=0x3C0, rn=7 -> one request, tag {7,0}, mem_req_both=1; outstanding +1. Without the macro the same pair gives two requests with mem_req_both=0.
